// File: rtl/mmio_controller.sv
// mmio_controller: memory-mapped debounced switch inputs, LED output registers,
// clear-on-read change STATUS and a masked interrupt.
module mmio_controller #(
  parameter int BASE_ADDR       = 4096,
  parameter int NUM_IN          = 2,
  parameter int NUM_OUT         = 2,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               address,
  input  logic                      wren,
  input  logic                      ren,
  input  logic [31:0]               data_in,
  output logic [31:0]               q_io,
  output logic                      io_hit,
  input  logic [NUM_IN*DATA_W-1:0]  in_raw,
  output logic [NUM_OUT*DATA_W-1:0] out_reg,
  output logic                      irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [31:0] ST_OFF = 32'(NUM_IN + NUM_OUT);
  localparam logic [31:0] MK_OFF = ST_OFF + 32'd1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] sync1_q [NUM_IN];
  logic [DATA_W-1:0] sync2_q [NUM_IN];
  logic [DATA_W-1:0] stable_q [NUM_IN];
  logic [DATA_W-1:0] stable_d [NUM_IN];
  logic [CW-1:0]     count_q [NUM_IN];
  logic [CW-1:0]     count_d [NUM_IN];
  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [DATA_W-1:0] out_d [NUM_OUT];
  logic [NUM_IN-1:0] status_q, status_d, mask_q, mask_d;
  logic              irq_q, irq_d;
  logic [31:0]       off;
  logic              rd_clr, unused_ok;

  // Offsets below BASE_ADDR wrap to huge values, so one compare covers both bounds.
  assign off       = address - 32'(BASE_ADDR);
  assign io_hit    = off <= MK_OFF;
  assign rd_clr    = ren && off == ST_OFF;
  assign irq       = irq_q;
  assign unused_ok = ^data_in;

  always_comb begin
    status_d = rd_clr ? '0 : status_q;
    q_io = (off == ST_OFF) ? 32'(status_q) : (off == MK_OFF) ? 32'(mask_q) : '0;
    for (int i = 0; i < NUM_IN; i++) begin
      stable_d[i] = stable_q[i];
      count_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (count_q[i] == LAST) begin
          stable_d[i] = sync2_q[i];
          status_d[i] = 1'b1;
        end else count_d[i] = count_q[i] + CW'(1);
      end
      if (off == 32'(i)) q_io = 32'(stable_q[i]);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      out_d[j] = (wren && off == 32'(NUM_IN + j)) ? data_in[DATA_W-1:0] : out_q[j];
      out_reg[j*DATA_W +: DATA_W] = out_q[j];
      if (off == 32'(NUM_IN + j)) q_io = 32'(out_q[j]);
    end
    mask_d = (wren && off == MK_OFF) ? data_in[NUM_IN-1:0] : mask_q;
    irq_d = |(status_d & mask_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
        stable_q[i] <= '0;
        count_q[i] <= '0;
      end
      for (int j = 0; j < NUM_OUT; j++) out_q[j] <= '0;
      status_q <= '0;
      mask_q <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_q[i] <= in_raw[i*DATA_W +: DATA_W];
        sync2_q[i] <= sync1_q[i];
        stable_q[i] <= stable_d[i];
        count_q[i] <= count_d[i];
      end
      for (int j = 0; j < NUM_OUT; j++) out_q[j] <= out_d[j];
      status_q <= status_d;
      mask_q <= mask_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed + random bus/switch traffic against a reference model checked by a negedge monitor
module tb_mmio_controller;
  localparam int BASE = 4096, NI = 2, NO = 2, DW = 16, DB = 4;
  localparam int N = BASE + NI + NO;

  logic clock = 0, reset = 0, wren = 0, ren = 0;
  logic [31:0] address = 0, data_in = 0, q_io;
  logic io_hit, irq;
  logic [NI*DW-1:0] in_raw = 0;
  logic [NO*DW-1:0] out_reg;

  always #5 clock = ~clock;

  mmio_controller #(.BASE_ADDR(BASE), .NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW),
                    .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .address(address), .wren(wren), .ren(ren),
    .data_in(data_in), .q_io(q_io), .io_hit(io_hit), .in_raw(in_raw),
    .out_reg(out_reg), .irq(irq));

  typedef struct {int kind; logic [31:0] exp; string name;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  logic [DW-1:0] m_s1[NI], m_s2[NI], m_st[NI], m_out[NO];
  int m_run[NI];
  logic [NI-1:0] m_status = 0, m_mask = 0;
  logic m_irq = 0;
  bit en = 0;

  function automatic bit m_hit(logic [31:0] a);
    longint off = longint'(a) - BASE;
    return off >= 0 && off <= NI + NO + 1;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    longint off = longint'(a) - BASE;
    if (off >= 0 && off < NI) return 32'(m_st[int'(off)]);
    if (off >= NI && off < NI + NO) return 32'(m_out[int'(off) - NI]);
    if (off == NI + NO) return 32'(m_status);
    if (off == NI + NO + 1) return 32'(m_mask);
    return 0;
  endfunction

  task automatic push(int kind, logic [31:0] exp, string name);
    sb.push_back('{kind, exp, name});
  endtask

  task automatic model_update(logic [31:0] a, bit wr, bit rd, logic [31:0] d);
    logic [NI-1:0] set;
    set = 0;
    if (!reset) begin
      for (int c = 0; c < NI; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_run[c] = 0;
      end
      for (int j = 0; j < NO; j++) m_out[j] = 0;
      m_status = 0; m_mask = 0; m_irq = 0;
    end else begin
      for (int c = 0; c < NI; c++) begin
        if (m_s2[c] == m_st[c]) m_run[c] = 0;
        else if (m_run[c] + 1 == DB) begin
          m_st[c] = m_s2[c]; set[c] = 1; m_run[c] = 0;
        end else m_run[c]++;
      end
      m_status = ((rd && a == N) ? '0 : m_status) | set;
      if (wr) begin
        if (a == N + 1) m_mask = d[NI-1:0];
        for (int j = 0; j < NO; j++) if (a == BASE + NI + j) m_out[j] = d[DW-1:0];
      end
      m_irq = |(m_status & m_mask);
      for (int c = 0; c < NI; c++) begin
        m_s2[c] = m_s1[c];
        m_s1[c] = in_raw[c*DW +: DW];
      end
    end
  endtask

  task automatic cycle(logic [31:0] a, bit wr, bit rd, logic [31:0] d);
    logic [31:0] po;
    address = a; wren = wr; ren = rd; data_in = d;
    if (en) begin
      for (int j = 0; j < NO; j++) po[j*DW +: DW] = m_out[j];
      push(3, 32'(m_hit(a)), "io_hit");
      push(1, 32'(m_irq), "irq");
      push(2, po, "out_reg");
      if (rd) push(0, m_read(a), "q_io");
    end
    @(posedge clock);
    model_update(a, wr, rd, d);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(32'd0, 0, 0, 32'd0);
  endtask

  exp_t e;
  logic [31:0] act;
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.kind == 0 ? q_io : e.kind == 1 ? 32'(irq) : e.kind == 2 ? 32'(out_reg) : 32'(io_hit);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    #1;
    reset = 0;
    idle(2);
    en = 1;
    cycle(BASE + 2, 0, 1, 32'd0);
    push(2, 32'd0, "rst_out_reg");
    push(1, 32'd0, "rst_irq");
    idle(1);
    reset = 1;
    idle(2);
    in_raw[15:0] = 16'h00A5;
    idle(5);
    push(0, 32'h0, "in0_before_e5");
    cycle(BASE, 0, 1, 0);
    push(0, 32'h00A5, "in0_after_e5");
    cycle(BASE, 0, 1, 0);
    push(0, 32'h1, "status_ch0");
    cycle(N, 0, 1, 0);
    in_raw[15:0] = 16'h00FF;
    idle(3);
    in_raw[15:0] = 16'h00A5;
    idle(8);
    push(0, 32'h00A5, "glitch_in0");
    cycle(BASE, 0, 1, 0);
    push(0, 32'h0, "glitch_status");
    push(1, 32'h0, "glitch_irq");
    cycle(N, 0, 1, 0);
    cycle(BASE + 2, 1, 0, 32'h12345678);
    push(2, 32'h00005678, "out0_store");
    push(0, 32'h00005678, "out0_read");
    cycle(BASE + 2, 0, 1, 0);
    cycle(BASE, 1, 0, 32'hFFFF);
    push(0, 32'h00A5, "in_store_ignored");
    cycle(BASE, 0, 1, 0);
    cycle(N + 1, 1, 0, 32'h2);
    in_raw[31:16] = 16'h1234;
    idle(5);
    push(1, 32'h0, "irq_before_flag");
    idle(1);
    push(1, 32'h1, "irq_at_flag");
    push(0, 32'h2, "status_read_ch1");
    cycle(N, 0, 1, 0);
    push(1, 32'h0, "irq_after_clear");
    idle(1);
    push(0, 32'h0, "status_cleared");
    cycle(N, 0, 1, 0);
    in_raw[15:0] = 16'h0F0F;
    idle(5);
    push(0, 32'h0, "status_read_at_flag");
    cycle(N, 0, 1, 0);
    push(0, 32'h1, "status_set_wins");
    cycle(N, 0, 1, 0);
    cycle(BASE + 2, 1, 0, 32'hFFFF);
    in_raw[31:16] = 16'h4321;
    idle(2);
    reset = 0;
    idle(1);
    push(2, 32'h0, "rst_mid_out");
    push(1, 32'h0, "rst_mid_irq");
    push(0, 32'h0, "rst_mid_in1");
    cycle(BASE + 1, 0, 1, 0);
    reset = 1;
    push(3, 32'h0, "unmapped_hit");
    push(0, 32'h0, "unmapped_q");
    cycle(32'd5000, 0, 1, 0);
    idle(8);
    push(0, 32'h4321, "in1_after_reset");
    cycle(BASE + 1, 0, 1, 0);
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NI; c++)
        if ($urandom_range(0, 7) == 0)
          in_raw[c*DW +: DW] = ($urandom_range(0, 1) == 0) ? DW'($urandom) : m_st[c];
      reset = ($urandom_range(0, 299) != 0);
      a = ($urandom_range(0, 19) == 0) ? 32'd5000 : 32'(BASE - 2 + $urandom_range(0, 9));
      cycle(a, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom);
    end
    reset = 1;
    idle(2);
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expectations not drained", sb.size());
    end
    if (total < 100) begin
      bad++;
      $display("FAIL coverage: only %0d comparisons ran", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0) $display("FAIL: %0d mismatches", bad);
    else $display("PASS");
    $finish;
  end
endmodule

// File: doc/mmio_controller.md
MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 Parameter BASE_ADDR, default 4096: word address of the first I/O register.
REQ-002 Parameter NUM_IN, default 2: number of input channels, switch-type, range 1..8.
REQ-003 Parameter NUM_OUT, default 2: number of output channels, LED-type, range 1..8.
REQ-004 Parameter DATA_W, default 16: width of each channel, range 1..32.
REQ-005 Parameter DEBOUNCE_CYCLES, default 4: required stable sampling edges, range 1..65535.
REQ-006 Port clock, input, 1 bit: single system clock; all state changes on its posedge.
REQ-007 Port reset, input, 1 bit: synchronous, active-low reset, sampled on posedge clock.
REQ-008 Port address, input, 32 bits: processor data-memory address.
REQ-009 Port wren, input, 1 bit: processor store strobe.
REQ-010 Port ren, input, 1 bit: processor load strobe.
REQ-011 Port data_in, input, 32 bits: store data.
REQ-012 Port q_io, output, 32 bits: combinational read data.
REQ-013 Port io_hit, output, 1 bit: combinational; address falls within this block's map.
REQ-014 Port in_raw, input, NUM_IN*DATA_W bits: asynchronous channel inputs; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-015 Port out_reg, output, NUM_OUT*DATA_W bits: registered channel outputs, same packing as in_raw.
REQ-016 Port irq, output, 1 bit: registered interrupt request.

Function
REQ-017 Address map, with N = BASE_ADDR + NUM_IN + NUM_OUT:
- BASE_ADDR+i: IN[i], read-only.
- BASE_ADDR+NUM_IN+j: OUT[j], read/write.
- N: STATUS, read-only, clear-on-read.
- N+1: MASK, read/write, width NUM_IN.
REQ-018 io_hit SHALL be 1 exactly when address lies in BASE_ADDR..N+1; otherwise q_io SHALL be 0.
REQ-019 Reads SHALL return the register value zero-extended to 32 bits.
REQ-020 Each input channel SHALL pass through a 2-flop synchronizer (sync1, sync2) before debounce.
REQ-021 Debounce, per channel, with counter width ceil(log2(DEBOUNCE_CYCLES))+1, applied at each edge:
- sync2 == stable: count <= 0.
- Else if count == DEBOUNCE_CYCLES-1: stable <= sync2 and count <= 0.
- Else: count <= count+1.
REQ-022 Debounce latency: a raw change that is settled before edge e0 SHALL appear in IN[i] after edge e(DEBOUNCE_CYCLES+1).
REQ-023 Any return of sync2 to stable before the debounce threshold SHALL restart the count, with no IN change.
REQ-024 STATUS bit i SHALL set on the same edge that stable[i] updates.
REQ-025 A read of STATUS (ren=1 at address N) SHALL clear all STATUS bits at that edge; q_io in that cycle shows the pre-clear value.
REQ-026 Simultaneous set and clear-on-read of a STATUS bit: the set SHALL win and the bit remains 1.
REQ-027 A store (wren=1) to OUT[j] SHALL update out_reg[j] with data_in[DATA_W-1:0] at that posedge; stores to MASK take data_in[NUM_IN-1:0].
REQ-028 Stores to IN, STATUS, or unmapped addresses SHALL be ignored; a read with ren=0 SHALL NOT clear STATUS.
REQ-029 irq SHALL be registered as |(STATUS & MASK) computed from next-state values, so it asserts on the same edge the flag sets.
REQ-030 wren and ren both high at the same address: the store SHALL apply and the read side-effect SHALL also apply.

Reset
REQ-031 While reset=0 at a posedge, the following SHALL clear to 0: sync1, sync2, stable, count, out_reg, STATUS, MASK, irq.
REQ-032 A reset asserted mid-debounce SHALL abort the count; after release, debounce restarts from stable=0.
REQ-033 Stores and reads presented while reset=0 SHALL have no effect.

Verification
REQ-034 DEBOUNCE_CYCLES=4: drive in_raw ch0 0->0x00A5 before e0 -> IN[0]=0x00A5 after e5, STATUS=0x1 at e5.
REQ-035 Pulse ch0 high for 3 cycles then back -> IN[0], STATUS, irq unchanged.
REQ-036 Store 0x12345678 to BASE_ADDR+2 -> out_reg[15:0]=0x5678 next edge; read returns 0x00005678; store to BASE_ADDR (IN[0]) -> no change.
REQ-037 MASK=0x2, ch1 change -> irq=1 at flag edge; read STATUS -> returns 0x2, then STATUS=0 and irq=0 next edge.
REQ-038 ch0 flag sets on the same edge as a STATUS read -> STATUS bit0 remains 1; read value excludes it.
REQ-039 Assert reset mid-count with out_reg=0xFFFF -> all registers and outputs are 0 next edge; address 5000 -> io_hit=0, q_io=0.
